// File: rtl/mc_control_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, instruction classes,
// ALU operation codes, opcode/funct values and the operand/PC mux selects.
package mc_control_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_RALU = 3'd0,
        CLS_IALU = 3'd1,
        CLS_LW   = 3'd2,
        CLS_SW   = 3'd3,
        CLS_BEQ  = 3'd4,
        CLS_BNE  = 3'd5,
        CLS_J    = 3'd6,
        CLS_ILL  = 3'd7
    } iclass_t;

    localparam logic [3:0] ALUC_ADD  = 4'b0000;
    localparam logic [3:0] ALUC_AND  = 4'b0001;
    localparam logic [3:0] ALUC_OR   = 4'b0010;
    localparam logic [3:0] ALUC_XOR  = 4'b0011;
    localparam logic [3:0] ALUC_SRA  = 4'b0100;
    localparam logic [3:0] ALUC_SRL  = 4'b0101;
    localparam logic [3:0] ALUC_SLL  = 4'b0110;
    localparam logic [3:0] ALUC_ADDI = 4'b0111;
    localparam logic [3:0] ALUC_ANDI = 4'b1000;
    localparam logic [3:0] ALUC_ORI  = 4'b1001;
    localparam logic [3:0] ALUC_XORI = 4'b1010;
    localparam logic [3:0] ALUC_LW   = 4'b1011;
    localparam logic [3:0] ALUC_SW   = 4'b1100;
    localparam logic [3:0] ALUC_BEQ  = 4'b1101;
    localparam logic [3:0] ALUC_BNE  = 4'b1110;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;

    localparam logic [1:0] BSEL_RT   = 2'd0;
    localparam logic [1:0] BSEL_SEXT = 2'd1;
    localparam logic [1:0] BSEL_ZEXT = 2'd2;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_control_alu_decoder.sv
// Combinational instruction decoder: op/funct to ALU code, operand selects and class.
// Fields are meaningful only when illegal is low.
module mc_control_alu_decoder
    import mc_control_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] aluc,
    output logic       alu_a_sel,
    output logic [1:0] alu_b_sel,
    output iclass_t    cls,
    output logic       illegal
);

    always_comb begin
        aluc      = ALUC_ADD;
        alu_a_sel = 1'b0;
        alu_b_sel = BSEL_RT;
        cls       = CLS_ILL;
        case (op)
            OP_RTYPE: begin
                cls = CLS_RALU;
                case (funct)
                    FN_ADD:  aluc = ALUC_ADD;
                    FN_AND:  aluc = ALUC_AND;
                    FN_OR:   aluc = ALUC_OR;
                    FN_XOR:  aluc = ALUC_XOR;
                    FN_SRA:  begin aluc = ALUC_SRA; alu_a_sel = 1'b1; end
                    FN_SRL:  begin aluc = ALUC_SRL; alu_a_sel = 1'b1; end
                    FN_SLL:  begin aluc = ALUC_SLL; alu_a_sel = 1'b1; end
                    default: cls = CLS_ILL;
                endcase
            end
            OP_ADDI: begin cls = CLS_IALU; aluc = ALUC_ADDI; alu_b_sel = BSEL_SEXT; end
            OP_ANDI: begin cls = CLS_IALU; aluc = ALUC_ANDI; alu_b_sel = BSEL_ZEXT; end
            OP_ORI:  begin cls = CLS_IALU; aluc = ALUC_ORI;  alu_b_sel = BSEL_ZEXT; end
            OP_XORI: begin cls = CLS_IALU; aluc = ALUC_XORI; alu_b_sel = BSEL_ZEXT; end
            OP_LW:   begin cls = CLS_LW;   aluc = ALUC_LW;   alu_b_sel = BSEL_SEXT; end
            OP_SW:   begin cls = CLS_SW;   aluc = ALUC_SW;   alu_b_sel = BSEL_SEXT; end
            OP_BEQ:  begin cls = CLS_BEQ;  aluc = ALUC_BEQ; end
            OP_BNE:  begin cls = CLS_BNE;  aluc = ALUC_BNE; end
            OP_J:    cls = CLS_J;
            default: cls = CLS_ILL;
        endcase
    end

    assign illegal = (cls == CLS_ILL);

endmodule

// File: rtl/mc_control.sv
// Multicycle IF/ID/EX/MEM/WB control FSM driving the ALU, PC, IR, memory and register file.
// All outputs are combinational from state and the IR fields, and forced to 0 while rst is high.
module mc_control
    import mc_control_pkg::*;
#(
    parameter bit TRAP_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       z,
    input  logic       mem_ready,
    output logic [3:0] aluc,
    output logic       alu_a_sel,
    output logic [1:0] alu_b_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       mem_req,
    output logic       mem_we,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal,
    output logic [2:0] state_dbg
);

    state_t     state, state_next;
    logic [3:0] dec_aluc;
    logic       dec_a_sel;
    logic [1:0] dec_b_sel;
    iclass_t    dec_cls;
    logic       dec_illegal;

    mc_control_alu_decoder u_dec (
        .op        (op),
        .funct     (funct),
        .aluc      (dec_aluc),
        .alu_a_sel (dec_a_sel),
        .alu_b_sel (dec_b_sel),
        .cls       (dec_cls),
        .illegal   (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IF;
        else     state <= state_next;
    end

    // Memory handshake: mem_req stays high until a cycle with mem_ready; that cycle
    // completes the transfer and is the only one in which the FSM leaves IF or MEM.
    always_comb begin
        state_next = state;
        aluc       = 4'b0000;
        alu_a_sel  = 1'b0;
        alu_b_sel  = BSEL_RT;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_PLUS4;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        state_dbg  = 3'd0;
        if (!rst) begin
            state_dbg = state;
            case (state)
                S_IF: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we      = 1'b1;
                        pc_we      = 1'b1;
                        state_next = S_ID;
                    end
                end
                S_ID: begin
                    if (dec_cls == CLS_J) begin
                        pc_we      = 1'b1;
                        pc_src     = PC_JUMP;
                        instr_done = 1'b1;
                        state_next = S_IF;
                    end else if (dec_illegal) begin
                        if (TRAP_ILLEGAL) begin
                            state_next = S_HALT;
                        end else begin
                            instr_done = 1'b1;
                            state_next = S_IF;
                        end
                    end else begin
                        state_next = S_EX;
                    end
                end
                S_EX: begin
                    aluc      = dec_aluc;
                    alu_a_sel = dec_a_sel;
                    alu_b_sel = dec_b_sel;
                    case (dec_cls)
                        CLS_BEQ, CLS_BNE: begin
                            pc_we      = (dec_cls == CLS_BEQ) ? z : ~z;
                            pc_src     = PC_BRANCH;
                            instr_done = 1'b1;
                            state_next = S_IF;
                        end
                        CLS_LW, CLS_SW: state_next = S_MEM;
                        default:        state_next = S_WB;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (dec_cls == CLS_SW);
                    if (mem_ready) begin
                        if (dec_cls == CLS_SW) begin
                            instr_done = 1'b1;
                            state_next = S_IF;
                        end else begin
                            state_next = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_we     = 1'b1;
                    reg_dst    = (dec_cls == CLS_RALU);
                    mem_to_reg = (dec_cls == CLS_LW);
                    instr_done = 1'b1;
                    state_next = S_IF;
                end
                S_HALT: illegal = 1'b1;
                default: state_next = S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control: per-instruction transaction summaries from a
// class-level timing/behaviour model are queued and compared at each instr_done.
module tb_mc_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst_nt, z, mem_ready;
  logic [5:0] op, funct;
  logic [3:0] aluc, aluc_nt;
  logic       alu_a_sel, alu_a_sel_nt, ir_we, ir_we_nt, pc_we, pc_we_nt;
  logic [1:0] alu_b_sel, alu_b_sel_nt, pc_src, pc_src_nt;
  logic       mem_req, mem_req_nt, mem_we, mem_we_nt, reg_we, reg_we_nt;
  logic       reg_dst, reg_dst_nt, mem_to_reg, mem_to_reg_nt;
  logic       instr_done, instr_done_nt, illegal, illegal_nt;
  logic [2:0] state_dbg, state_dbg_nt;

  mc_control #(.TRAP_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .z(z), .mem_ready(mem_ready),
    .aluc(aluc), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we),
    .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .instr_done(instr_done), .illegal(illegal), .state_dbg(state_dbg)
  );

  mc_control #(.TRAP_ILLEGAL(1'b0)) dut_nt (
    .clk(clk), .rst(rst_nt), .op(op), .funct(funct), .z(z), .mem_ready(mem_ready),
    .aluc(aluc_nt), .alu_a_sel(alu_a_sel_nt), .alu_b_sel(alu_b_sel_nt), .ir_we(ir_we_nt),
    .pc_we(pc_we_nt), .pc_src(pc_src_nt), .mem_req(mem_req_nt), .mem_we(mem_we_nt),
    .reg_we(reg_we_nt), .reg_dst(reg_dst_nt), .mem_to_reg(mem_to_reg_nt),
    .instr_done(instr_done_nt), .illegal(illegal_nt), .state_dbg(state_dbg_nt)
  );

  // Layout: aluc[17:14] a_sel[13] b_sel[12:11] ir_we[10] pc_we[9] pc_src[8:7]
  // mem_req[6] mem_we[5] reg_we[4] reg_dst[3] mem_to_reg[2] instr_done[1] illegal[0]
  logic [17:0] all_out, all_out_nt;
  assign all_out = {aluc, alu_a_sel, alu_b_sel, ir_we, pc_we, pc_src, mem_req, mem_we,
                    reg_we, reg_dst, mem_to_reg, instr_done, illegal};
  assign all_out_nt = {aluc_nt, alu_a_sel_nt, alu_b_sel_nt, ir_we_nt, pc_we_nt, pc_src_nt,
                       mem_req_nt, mem_we_nt, reg_we_nt, reg_dst_nt, mem_to_reg_nt,
                       instr_done_nt, illegal_nt};

  typedef struct packed {
    logic [7:0] cycles;
    logic [3:0] aluc;
    logic       a_sel;
    logic [1:0] b_sel;
    logic [7:0] n_req;
    logic [7:0] n_we;
    logic [3:0] n_ir;
    logic [3:0] n_pc;
    logic [1:0] pc_src_last;
    logic [3:0] n_reg;
    logic       reg_dst;
    logic       m2r;
    logic [3:0] n_ill;
  } txn_t;
  localparam int TW = $bits(txn_t);

  logic [TW-1:0] exp_q[$];
  string         name_q[$];
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Instruction table written straight from the ISA description.
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5, K_J = 6;
  localparam int NI = 16;
  logic [5:0] t_op[NI];
  logic [5:0] t_fn[NI];
  logic [3:0] t_aluc[NI];
  logic       t_a[NI];
  logic [1:0] t_b[NI];
  int         t_kind[NI];
  string      t_nm[NI];

  task automatic def(input int i, input string nm, input logic [5:0] o, input logic [5:0] f,
                     input int k, input logic [3:0] ac, input logic a, input logic [1:0] b);
    t_nm[i] = nm; t_op[i] = o; t_fn[i] = f; t_kind[i] = k;
    t_aluc[i] = ac; t_a[i] = a; t_b[i] = b;
  endtask

  function automatic txn_t model(input int i, input logic zz, input int wi, input int wm);
    txn_t t;
    int   k;
    bit   is_mem, taken, writes;
    k      = t_kind[i];
    is_mem = (k == K_LW) || (k == K_SW);
    taken  = ((k == K_BEQ) && zz) || ((k == K_BNE) && !zz);
    writes = (k == K_R) || (k == K_I) || (k == K_LW);
    t = '0;
    case (k)
      K_J:          t.cycles = 8'(2 + wi);
      K_BEQ, K_BNE: t.cycles = 8'(3 + wi);
      K_LW:         t.cycles = 8'(5 + wi + wm);
      K_SW:         t.cycles = 8'(4 + wi + wm);
      default:      t.cycles = 8'(4 + wi);
    endcase
    if (k != K_J) begin
      t.aluc  = t_aluc[i];
      t.a_sel = t_a[i];
      t.b_sel = t_b[i];
    end
    t.n_req       = 8'(1 + wi + (is_mem ? 1 + wm : 0));
    t.n_we        = (k == K_SW) ? 8'(1 + wm) : 8'd0;
    t.n_ir        = 4'd1;
    t.n_pc        = ((k == K_J) || taken) ? 4'd2 : 4'd1;
    t.pc_src_last = (k == K_J) ? 2'd2 : (taken ? 2'd1 : 2'd0);
    t.n_reg       = writes ? 4'd1 : 4'd0;
    t.reg_dst     = writes && (k == K_R);
    t.m2r         = (k == K_LW);
    return t;
  endfunction

  task automatic noise_cycle();
    @(posedge clk); #1;
    mem_ready = 1'($urandom_range(0, 1));
  endtask

  // Drives one instruction on a fixed schedule; mem_ready is random outside IF/MEM.
  task automatic run_instr(input int i, input logic zz, input int wi, input int wm);
    int k;
    k = t_kind[i];
    exp_q.push_back(TW'(model(i, zz, wi, wm)));
    name_q.push_back(t_nm[i]);
    for (int c = 0; c <= wi; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        rst   = 1'b0;
        op    = t_op[i];
        funct = (k == K_R) ? t_fn[i] : 6'($urandom_range(0, 63));
        z     = zz;
      end
      mem_ready = (c == wi);
    end
    noise_cycle();
    if (k != K_J) begin
      noise_cycle();
      if ((k == K_LW) || (k == K_SW)) begin
        for (int c = 0; c <= wm; c++) begin
          @(posedge clk); #1;
          mem_ready = (c == wm);
        end
      end
      if ((k == K_R) || (k == K_I) || (k == K_LW)) noise_cycle();
    end
  endtask

  // Monitor: accumulates what the DUT did since the last retire, compares on instr_done.
  int         m_cyc = 0, m_req = 0, m_we = 0, m_ir = 0, m_pc = 0, m_reg = 0, m_ill = 0;
  int         m_since = 100;
  logic [1:0] m_src = '0;
  logic       m_rd = 1'b0, m_m2r = 1'b0, m_a = 1'b0;
  logic [3:0] m_aluc = '0;
  logic [1:0] m_b = '0;

  task automatic clear_mon();
    m_cyc = 0; m_req = 0; m_we = 0; m_ir = 0; m_pc = 0; m_reg = 0; m_ill = 0;
    m_since = 100; m_src = '0; m_rd = 1'b0; m_m2r = 1'b0;
    m_aluc = '0; m_a = 1'b0; m_b = '0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      clear_mon();
    end else begin
      txn_t  obs;
      string nm;
      m_cyc++;
      if (mem_req) m_req++;
      if (mem_we)  m_we++;
      if (ir_we)   m_ir++;
      if (illegal) m_ill++;
      if (pc_we)  begin m_pc++; m_src = pc_src; end
      if (reg_we) begin m_reg++; m_rd = reg_dst; m_m2r = mem_to_reg; end
      if (ir_we) m_since = 0;
      else if (m_since < 100) m_since++;
      if (m_since == 2) begin m_aluc = aluc; m_a = alu_a_sel; m_b = alu_b_sel; end
      if (instr_done) begin
        obs = '{cycles: 8'(m_cyc), aluc: m_aluc, a_sel: m_a, b_sel: m_b,
                n_req: 8'(m_req), n_we: 8'(m_we), n_ir: 4'(m_ir), n_pc: 4'(m_pc),
                pc_src_last: m_src, n_reg: 4'(m_reg), reg_dst: m_rd, m2r: m_m2r,
                n_ill: 4'(m_ill)};
        if (exp_q.size() == 0) begin
          check("unexpected_instr_done", 64'(obs), 64'(0));
        end else begin
          nm = name_q.pop_front();
          check({"txn_", nm}, 64'(obs), 64'(exp_q.pop_front()));
        end
        clear_mon();
      end
    end
  end

  initial begin
    int rw;
    def(0,  "add",  6'b000000, 6'b100000, K_R,   4'b0000, 1'b0, 2'd0);
    def(1,  "and",  6'b000000, 6'b100100, K_R,   4'b0001, 1'b0, 2'd0);
    def(2,  "or",   6'b000000, 6'b100101, K_R,   4'b0010, 1'b0, 2'd0);
    def(3,  "xor",  6'b000000, 6'b100110, K_R,   4'b0011, 1'b0, 2'd0);
    def(4,  "sra",  6'b000000, 6'b000011, K_R,   4'b0100, 1'b1, 2'd0);
    def(5,  "srl",  6'b000000, 6'b000010, K_R,   4'b0101, 1'b1, 2'd0);
    def(6,  "sll",  6'b000000, 6'b000000, K_R,   4'b0110, 1'b1, 2'd0);
    def(7,  "addi", 6'b001000, 6'b000000, K_I,   4'b0111, 1'b0, 2'd1);
    def(8,  "andi", 6'b001100, 6'b000000, K_I,   4'b1000, 1'b0, 2'd2);
    def(9,  "ori",  6'b001101, 6'b000000, K_I,   4'b1001, 1'b0, 2'd2);
    def(10, "xori", 6'b001110, 6'b000000, K_I,   4'b1010, 1'b0, 2'd2);
    def(11, "lw",   6'b100011, 6'b000000, K_LW,  4'b1011, 1'b0, 2'd1);
    def(12, "sw",   6'b101011, 6'b000000, K_SW,  4'b1100, 1'b0, 2'd1);
    def(13, "beq",  6'b000100, 6'b000000, K_BEQ, 4'b1101, 1'b0, 2'd0);
    def(14, "bne",  6'b000101, 6'b000000, K_BNE, 4'b1110, 1'b0, 2'd0);
    def(15, "j",    6'b000010, 6'b000000, K_J,   4'b0000, 1'b0, 2'd0);

    rst = 1'b1; rst_nt = 1'b1; op = '0; funct = '0; z = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'(all_out), 64'(0));
    check("reset_outputs_nt", 64'(all_out_nt), 64'(0));
    check("reset_state_dbg", 64'({state_dbg, state_dbg_nt}), 64'(0));

    // Directed cases, then random instruction mix with random memory latency.
    run_instr(0, 1'b0, 0, 0);
    run_instr(11, 1'b0, 2, 2);
    run_instr(13, 1'b1, 0, 0);
    run_instr(13, 1'b0, 0, 0);
    run_instr(14, 1'b0, 0, 0);
    run_instr(14, 1'b1, 1, 0);
    run_instr(6, 1'b0, 0, 0);
    run_instr(4, 1'b0, 0, 0);
    run_instr(5, 1'b0, 0, 0);
    run_instr(15, 1'b0, 0, 0);
    run_instr(12, 1'b1, 1, 3);
    for (int n = 0; n < 70; n++)
      run_instr(int'($urandom_range(0, NI - 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    // Reset during EX of an add abandons it with no register write.
    rw = 0;
    @(posedge clk); #1; op = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
    @(negedge clk); rw += int'(reg_we);
    @(posedge clk); #1; mem_ready = 1'b0;
    @(negedge clk); rw += int'(reg_we);
    @(posedge clk); #1; rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_ex_outputs", 64'(all_out), 64'(0));
    rw += int'(reg_we);
    fork
      run_instr(7, 1'b0, 1, 0);
      begin
        @(posedge clk); @(negedge clk);
        check("rst_exit_if_wait", 64'(all_out), 64'(18'h00040));
        rw += int'(reg_we);
      end
    join
    check("rst_no_reg_we", 64'(rw), 64'(0));

    // Illegal opcode with trapping: HALT holds with no enables until reset.
    @(posedge clk); #1; op = 6'b111111; funct = 6'($urandom_range(0, 63)); mem_ready = 1'b1;
    @(posedge clk); #1; mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("halt_id_quiet", 64'(all_out), 64'(0));
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1; mem_ready = 1'($urandom_range(0, 1)); z = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("halt_hold", 64'(all_out), 64'(18'h00001));
    end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("halt_reset_outputs", 64'(all_out), 64'(0));
    run_instr(9, 1'b0, 0, 0);

    // Illegal opcode without trapping: retired in ID, back to IF.
    @(posedge clk); #1;
    rst = 1'b1; rst_nt = 1'b0; op = 6'b111111; funct = 6'($urandom_range(0, 63)); mem_ready = 1'b1;
    @(negedge clk);
    check("nt_if_fetch", 64'(all_out_nt), 64'(18'h00640));
    @(posedge clk); #1; mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("nt_id_done", 64'(all_out_nt), 64'(18'h00002));
    @(posedge clk); #1; mem_ready = 1'b0;
    @(negedge clk);
    check("nt_back_to_if", 64'(all_out_nt), 64'(18'h00040));
    @(posedge clk); #1; rst_nt = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle control unit that sits directly upstream of the ALU in the MIPS-subset CPU.
- Steps each instruction through IF/ID/EX/MEM/WB and drives the ALU's 4-bit aluc code, its operand-mux selects, and the PC, IR, memory and register-file enables.
- Consumes the ALU's z flag in EX to resolve beq/bne.
- Handshakes with a variable-latency memory through mem_req/mem_ready.

Parameters:
- TRAP_ILLEGAL, 1, 1: an unknown opcode/funct parks the FSM in HALT until reset; 0: it is retired as a NOP (back to IF).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- op  in  6  IR[31:26], stable from ID onward
- funct  in  6  IR[5:0]
- z  in  1  ALU zero flag, combinational, same cycle as aluc
- mem_ready  in  1  memory completes the current request this cycle
- aluc  out  4  ALU operation code
- alu_a_sel  out  1  0 = rs, 1 = zero-extended shamt (shift amount enters ALU input a[4:0])
- alu_b_sel  out  2  0 = rt, 1 = sign-extended imm16, 2 = zero-extended imm16
- ir_we  out  1  latch instruction
- pc_we  out  1  load PC
- pc_src  out  2  0 = pc+4, 1 = branch target, 2 = jump target
- mem_req  out  1  memory request
- mem_we  out  1  store when mem_req
- reg_we  out  1  register-file write
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  writeback source: 0 = ALU result, 1 = load data
- instr_done  out  1  one-cycle pulse on the last cycle of every retired instruction
- illegal  out  1  high while in HALT

Behaviour:
- States: IF, ID, EX, MEM, WB, HALT.
- Reset: rst sampled high -> state = IF next edge. While rst is high, every output is 0. Reset mid-instruction abandons it; no write enable fires on the reset cycle.
- All outputs are decoded combinationally from the state plus the latched op/funct. Outputs are 0 unless stated below.

IF:
- mem_req = 1, mem_we = 0.
- On mem_ready = 1: ir_we = 1, pc_we = 1, pc_src = 0, then -> ID.
- On mem_ready = 0: hold, and keep mem_req = 1. Zero-wait memory is legal (ready in the first IF cycle).

ID:
- Decode -> EX, except j.
- j: pc_we = 1, pc_src = 2, instr_done = 1, -> IF.
- Illegal instruction: -> HALT when TRAP_ILLEGAL = 1, else instr_done = 1 and -> IF.

EX (aluc per class, from the fixed encoding):
- R-type add 0000, and 0001, or 0010, xor 0011, b = rt.
- Shifts set alu_a_sel = 1: sra 0100, srl 0101, sll 0110.
- addi 0111, b = sext.
- andi 1000, ori 1001, xori 1010, b = zext.
- lw 1011, sw 1100, b = sext.
- beq 1101, bne 1110, b = rt. pc_we = (beq & z) | (bne & ~z), pc_src = 1, instr_done = 1, -> IF.
- ALU classes -> WB. lw/sw -> MEM.
- aluc is held stable for the whole EX cycle.

MEM:
- mem_req = 1, mem_we = is_sw. Hold until mem_ready.
- sw: instr_done = 1 on the ready cycle, -> IF.
- lw: -> WB.

WB:
- reg_we = 1. reg_dst = 1 for R-type, else 0. mem_to_reg = is_lw.
- instr_done = 1, -> IF.

Decode table:
- op 000000 with funct 100000 add, 100100 and, 100101 or, 100110 xor, 000000 sll, 000010 srl, 000011 sra.
- op 001000 addi, 001100 andi, 001101 ori, 001110 xori, 100011 lw, 101011 sw, 000100 beq, 000101 bne, 000010 j.
- Anything else is illegal.

Cycle counts with zero-wait memory: j 2, beq/bne 3, sw 4, ALU ops 4, lw 5. Each mem_ready wait cycle adds 1.

Other rules:
- A mem_ready pulse outside IF/MEM is ignored.
- HALT exits only on rst.

Decomposition:
- Shared package: aluc code constants, opcode/funct constants, state encoding, alu_b_sel and pc_src encodings. The ALU and datapath use the same constants.
- One natural sub-module: alu_decoder. It is combinational, op/funct -> {aluc, alu_a_sel, alu_b_sel, instruction class, illegal}. The FSM stays in mc_control.

Test Plan:
- Reset mid-EX of an add (rst = 1 for one cycle) -> all outputs 0 that cycle; next cycle IF with mem_req = 1; reg_we never pulses.
- add (op 0, funct 100000), zero-wait memory -> aluc = 0000 in EX, reg_we = 1 with reg_dst = 1 in WB; instr_done on cycle 4.
- lw with 2 wait cycles on each of IF and MEM -> mem_req stays high through the waits; aluc = 1011, alu_b_sel = 1; reg_we with mem_to_reg = 1; done after 9 cycles.
- beq with z = 1 -> EX aluc = 1101, pc_we = 1, pc_src = 1. Repeat with z = 0 -> pc_we = 0. bne with z = 0 -> pc_we = 1.
- sll (funct 000000) -> aluc = 0110, alu_a_sel = 1. sra -> 0100. srl -> 0101.
- op 111111 -> TRAP_ILLEGAL = 1: illegal = 1 and HALT holds for 20 cycles with no enables until rst. TRAP_ILLEGAL = 0: instr_done at ID, next IF.
